write_buffer: RTL and testbench

// Posted-write buffer between the write-through cache controller and main data memory.

---
 rtl/write_buffer_if.sv | 33 +++
 rtl/write_buffer.sv | 126 ++++++++++++
 tb/tb_write_buffer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/write_buffer_if.sv
// Bundles the store-side, forwarding and memory-side signals of the posted-write buffer.
// The master modport is the environment (CPU/cache plus memory); the slave modport is the buffer.
interface write_buffer_if #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 10,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               wr_req;
  logic [ADDRESS-1:0] wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic               wr_full;
  logic [ADDRESS-1:0] rd_addr;
  logic               rd_hit;
  logic [WIDTH-1:0]   rd_hit_data;
  logic               mem_wr_en;
  logic [ADDRESS-1:0] mem_wr_addr;
  logic [WIDTH-1:0]   mem_wr_data;
  logic               mem_wr_ready;
  logic               empty;
  logic [CW-1:0]      count;

  modport master (
    output wr_req, wr_addr, wr_data, rd_addr, mem_wr_ready,
    input  wr_full, rd_hit, rd_hit_data, mem_wr_en, mem_wr_addr, mem_wr_data, empty, count
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_addr, mem_wr_ready,
    output wr_full, rd_hit, rd_hit_data, mem_wr_en, mem_wr_addr, mem_wr_data, empty, count
  );
endinterface

// File: rtl/write_buffer.sv
// Posted-write FIFO between a write-through cache and main memory, with
// read-after-write forwarding of the newest queued store to a matching load address.
module write_buffer #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 10,
  parameter int DEPTH   = 4
) (
  input logic           clk,
  input logic           rst,
  write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [ADDRESS-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0]   data_mem [DEPTH];

  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [0:0]         state_q, state_d;
  logic               en_q, en_d;
  logic [ADDRESS-1:0] maddr_q, maddr_d;
  logic [WIDTH-1:0]   mdata_q, mdata_d;

  logic full, push, pop;

  // Full is judged on the current count, so a simultaneous pop cannot admit a push.
  assign full = (count_q == CW'(DEPTH));
  assign push = bus.wr_req && !full;
  assign pop  = (state_q == ST_WRITE) && bus.mem_wr_ready;

  always_ff @(posedge clk) begin
    if (rst && push) begin
      addr_mem[tail_q] <= bus.wr_addr;
      data_mem[tail_q] <= bus.wr_data;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    en_d    = en_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;

    if (push) tail_d = tail_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_WRITE;
          en_d    = 1'b1;
          maddr_d = addr_mem[head_q];
          mdata_d = data_mem[head_q];
        end
      end
      default: begin
        if (bus.mem_wr_ready) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          head_d  = head_q + PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      en_q    <= en_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  // Entries are examined oldest to newest, so the newest match overwrites older ones.
  logic [PW-1:0]    age_idx [DEPTH];
  logic [DEPTH-1:0] age_match;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    assign age_idx[gi]   = head_q + PW'(gi);
    assign age_match[gi] = (CW'(gi) < count_q) && (addr_mem[age_idx[gi]] == bus.rd_addr);
  end

  logic             hit;
  logic [WIDTH-1:0] hit_data;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_match[k]) begin
        hit      = 1'b1;
        hit_data = data_mem[age_idx[k]];
      end
    end
  end

  assign bus.wr_full     = full;
  assign bus.empty       = (count_q == '0);
  assign bus.count       = count_q;
  assign bus.rd_hit      = hit;
  assign bus.rd_hit_data = hit_data;
  assign bus.mem_wr_en   = en_q;
  assign bus.mem_wr_addr = maddr_q;
  assign bus.mem_wr_data = mdata_q;
endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a vector table for forwarding/drain behaviour plus
// hand-written sequences for reset, latency, full-buffer and mid-drain reset corners.
module tb_write_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  write_buffer_if #(.WIDTH(32), .ADDRESS(10), .DEPTH(4)) bus ();

  write_buffer #(.WIDTH(32), .ADDRESS(10), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        wr_req;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic        ready;
    logic [2:0]  count;
    logic        en;
    logic [9:0]  maddr;
    logic [31:0] mdata;
    logic        hit;
    logic [31:0] hdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [9:0] a, input logic [31:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    cyc();
    bus.wr_req  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.wr_req = 1'b0;
    bus.mem_wr_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  logic [9:0]  exp_a [4];
  logic [31:0] exp_d [4];

  task automatic drain_expect(input string name);
    int got;
    got = 0;
    bus.mem_wr_ready = 1'b1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (bus.mem_wr_en) begin
        check({name, "_addr"}, 128'(bus.mem_wr_addr), 128'(exp_a[got]));
        check({name, "_data"}, 128'(bus.mem_wr_data), 128'(exp_d[got]));
        got++;
      end
      cyc();
    end
    check({name, "_count"}, 128'(got), 128'(4));
    check({name, "_empty"}, 128'(bus.empty), 128'(1));
    bus.mem_wr_ready = 1'b0;
  endtask

  initial begin
    int highs;
    vec_t v;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    bus.mem_wr_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Test 1: idle after reset with ready asserted.
    bus.mem_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t1_idle_c%0d", i), {bus.empty, bus.count, bus.mem_wr_en, bus.wr_full},
            {1'b1, 3'd0, 1'b0, 1'b0});
      cyc();
    end

    // Test 2: single store latency and one-cycle request.
    push(10'h005, 32'hDEADBEEF);
    check("t2_after_push_en", 128'(bus.mem_wr_en), 128'(0));
    check("t2_after_push_cnt", 128'(bus.count), 128'(1));
    cyc();
    check("t2_req", {bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data}, {1'b1, 10'h005, 32'hDEADBEEF});
    cyc();
    check("t2_done", {bus.mem_wr_en, bus.empty}, {1'b0, 1'b1});
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_wr_en) highs++;
      cyc();
    end
    check("t2_no_repeat", 128'(highs), 128'(0));

    // Test 3: five stores with memory stalled; fifth is dropped.
    bus.mem_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(10'h100 + 10'(i), 32'h1000 + 32'(i));
    check("t3_count", 128'(bus.count), 128'(4));
    check("t3_full", 128'(bus.wr_full), 128'(1));
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = 10'h100 + 10'(i);
      exp_d[i] = 32'h1000 + 32'(i);
    end
    drain_expect("t3_drain");

    // Test 5: push while full on a pop edge is refused; next push accepted.
    for (int i = 0; i < 4; i++) push(10'h200 + 10'(i), 32'h2000 + 32'(i));
    cyc();
    check("t5_full_in_write", {bus.count, bus.mem_wr_en}, {3'd4, 1'b1});
    bus.wr_req = 1'b1;
    bus.wr_addr = 10'h2AA;
    bus.wr_data = 32'hBAD0BAD0;
    bus.mem_wr_ready = 1'b1;
    cyc();
    check("t5_pop_refuse", {bus.count, bus.wr_full}, {3'd3, 1'b0});
    bus.wr_addr = 10'h2BB;
    bus.wr_data = 32'h600D600D;
    bus.mem_wr_ready = 1'b0;
    cyc();
    bus.wr_req = 1'b0;
    check("t5_refill", {bus.count, bus.wr_full}, {3'd4, 1'b1});
    exp_a[0] = 10'h201; exp_d[0] = 32'h2001;
    exp_a[1] = 10'h202; exp_d[1] = 32'h2002;
    exp_a[2] = 10'h203; exp_d[2] = 32'h2003;
    exp_a[3] = 10'h2BB; exp_d[3] = 32'h600D600D;
    drain_expect("t5_drain");

    // Test 6: reset mid-drain discards everything.
    do_reset();
    for (int i = 0; i < 3; i++) push(10'h300 + 10'(i), 32'h3000 + 32'(i));
    check("t6_in_write", {bus.count, bus.mem_wr_en}, {3'd3, 1'b1});
    rst = 1'b0;
    cyc();
    check("t6_reset", {bus.count, bus.mem_wr_en, bus.empty, bus.mem_wr_addr, bus.mem_wr_data},
          {3'd0, 1'b0, 1'b1, 10'h0, 32'h0});
    rst = 1'b1;
    bus.mem_wr_ready = 1'b1;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_wr_en) highs++;
      cyc();
    end
    check("t6_no_stale", 128'(highs), 128'(0));

    // Table: forwarding (test 4), drain ordering and pointer wrap.
    do_reset();
    vecs[0]  = '{1'b1, 10'h010, 32'd1,        10'h010, 1'b0, 3'd1, 1'b0, 10'h000, 32'd0,        1'b1, 32'd1};
    vecs[1]  = '{1'b1, 10'h010, 32'd2,        10'h010, 1'b0, 3'd2, 1'b1, 10'h010, 32'd1,        1'b1, 32'd2};
    vecs[2]  = '{1'b1, 10'h011, 32'd3,        10'h010, 1'b0, 3'd3, 1'b1, 10'h010, 32'd1,        1'b1, 32'd2};
    vecs[3]  = '{1'b0, 10'h000, 32'd0,        10'h3FF, 1'b0, 3'd3, 1'b1, 10'h010, 32'd1,        1'b0, 32'd0};
    vecs[4]  = '{1'b0, 10'h000, 32'd0,        10'h011, 1'b0, 3'd3, 1'b1, 10'h010, 32'd1,        1'b1, 32'd3};
    vecs[5]  = '{1'b0, 10'h000, 32'd0,        10'h010, 1'b1, 3'd2, 1'b0, 10'h010, 32'd1,        1'b1, 32'd2};
    vecs[6]  = '{1'b0, 10'h000, 32'd0,        10'h010, 1'b1, 3'd2, 1'b1, 10'h010, 32'd2,        1'b1, 32'd2};
    vecs[7]  = '{1'b0, 10'h000, 32'd0,        10'h010, 1'b1, 3'd1, 1'b0, 10'h010, 32'd2,        1'b0, 32'd0};
    vecs[8]  = '{1'b1, 10'h3FF, 32'hCAFEF00D, 10'h3FF, 1'b0, 3'd2, 1'b1, 10'h011, 32'd3,        1'b1, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 10'h000, 32'd0,        10'h011, 1'b1, 3'd1, 1'b0, 10'h011, 32'd3,        1'b0, 32'd0};
    vecs[10] = '{1'b0, 10'h000, 32'd0,        10'h3FF, 1'b1, 3'd1, 1'b1, 10'h3FF, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 10'h000, 32'd0,        10'h3FF, 1'b1, 3'd0, 1'b0, 10'h3FF, 32'hCAFEF00D, 1'b0, 32'd0};

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      bus.wr_req = v.wr_req;
      bus.wr_addr = v.wr_addr;
      bus.wr_data = v.wr_data;
      bus.rd_addr = v.rd_addr;
      bus.mem_wr_ready = v.ready;
      cyc();
      check($sformatf("vec%0d", i),
            {bus.count, bus.wr_full, bus.empty, bus.mem_wr_en, bus.mem_wr_addr,
             bus.mem_wr_data, bus.rd_hit, bus.rd_hit_data},
            {v.count, (v.count == 3'd4), (v.count == 3'd0), v.en, v.maddr,
             v.mdata, v.hit, v.hdata});
    end
    bus.wr_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
